// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the CPU (m0), the loader/DMA (m1), the port arbiter
// and the unified instruction/data memory.
interface mem_port_arbiter_if;
   logic        m0_req;
   logic        m1_req;
   logic        m0_we;
   logic        m1_we;
   logic [31:0] m0_addr;
   logic [31:0] m1_addr;
   logic [31:0] m0_wdata;
   logic [31:0] m1_wdata;
   logic        m0_gnt;
   logic        m1_gnt;
   logic        m0_done;
   logic        m1_done;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;

   // Arbiter side: serves the two requesters and drives the memory strobes.
   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
      input  mem_rdata,
      output m0_gnt, m1_gnt, m0_done, m1_done, rdata,
      output mem_addr, mem_wdata, mem_rd, mem_wr
   );

   // Requester/memory side.
   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
      output mem_rdata,
      input  m0_gnt, m1_gnt, m0_done, m1_done, rdata,
      input  mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single memory port: IDLE -> ACCESS (MEM_LAT cycles) -> DONE.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed priority to m0.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;
   logic        last_beat;
   logic        pick_m1;
   logic        owner_p0;      // 1 = m1 owns the port
   logic        we_p0;
   logic [31:0] addr_p0;
   logic [31:0] wdata_p0;
   logic [31:0] rdata_p1;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_m1_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         last_m1_q <= 1'b1;
      end else if (state_q == DONE) begin
         last_m1_q <= owner_p0;
      end
   end

   // On contention the master that was not served last wins.
   assign pick_m1 = bus.m1_req & (~bus.m0_req | ~last_m1_q);
`else
   assign pick_m1 = bus.m1_req & ~bus.m0_req;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      accept        = 1'b0;
      last_beat     = 1'b0;
      bus.m0_gnt    = 1'b0;
      bus.m1_gnt    = 1'b0;
      bus.m0_done   = 1'b0;
      bus.m1_done   = 1'b0;
      bus.rdata     = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.m0_req | bus.m1_req) begin
               accept  = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            bus.m0_gnt    = ~owner_p0;
            bus.m1_gnt    = owner_p0;
            bus.mem_addr  = addr_p0;
            bus.mem_wdata = wdata_p0;
            bus.mem_rd    = ~we_p0;
            bus.mem_wr    = we_p0;
            if (cnt_q == 4'd0) begin
               last_beat = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            bus.m0_gnt  = ~owner_p0;
            bus.m1_gnt  = owner_p0;
            bus.m0_done = ~owner_p0;
            bus.m1_done = owner_p0;
            bus.rdata   = rdata_p1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and the read-data holding register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         owner_p0 <= 1'b0;
         rdata_p1 <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            owner_p0 <= pick_m1;
         end
         if (last_beat && !we_p0) begin
            rdata_p1 <= bus.mem_rdata;
         end
      end
   end

   // Winner's request captured at acceptance; later input changes are ignored.
   always_ff @(posedge CLK) begin
      if (accept) begin
         we_p0    <= pick_m1 ? bus.m1_we    : bus.m0_we;
         addr_p0  <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
         wdata_p0 <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
      end
   end

endmodule
